// File: rtl/simon_control_gen_if.sv
// Handshake bundle between the Simon controller and the pattern datapath / LEDs.
// The master drives step and the compare results; the slave is the controller.
interface simon_control_gen_if #(
    parameter int IDX_W  = 5,
    parameter int LIFE_W = 2
);
    logic              step;
    logic              valid_input;
    logic              valid_repeat;
    logic              mem_we;
    logic [IDX_W-1:0]  n;
    logic [IDX_W-1:0]  i;
    logic              input_led_pattern;
    logic [2:0]        mode_leds;
    logic [LIFE_W-1:0] lives;
    logic              won;

    modport master (
        output step, valid_input, valid_repeat,
        input  mem_we, n, i, input_led_pattern, mode_leds, lives, won
    );

    modport slave (
        input  step, valid_input, valid_repeat,
        output mem_we, n, i, input_led_pattern, mode_leds, lives, won
    );
endinterface

// File: rtl/simon_control_gen.sv
// Simon game controller: owns level count n, playback/repeat index i,
// a playback hold timer and a lives counter. All state advances only on
// clock edges where step is high, so the clock may run free.
module simon_control_gen #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 5,
    parameter int HOLD   = 1,
    parameter int LIVES  = 3,
    parameter int LIFE_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    simon_control_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_INPUT    = 2'd0,
        ST_PLAYBACK = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [IDX_W-1:0]  DEPTH_C   = IDX_W'(DEPTH);
    localparam logic [LIFE_W-1:0] LIVES_C   = LIFE_W'(LIVES);

    state_t             state_r,  state_nxt_s;
    logic [IDX_W-1:0]   n_r,      n_nxt_s;
    logic [IDX_W-1:0]   i_r,      i_nxt_s;
    logic [HOLD_W-1:0]  hold_r,   hold_nxt_s;
    logic [LIFE_W-1:0]  lives_r,  lives_nxt_s;
    logic               won_r,    won_nxt_s;
    logic [IDX_W-1:0]   last_s;
    logic [2:0]         mode_leds_s;
    logic               input_led_pattern_s;
    logic               mem_we_s;

    // Index of the last stored pattern; only meaningful when n >= 1.
    assign last_s = n_r - IDX_W'(1);

    // State and counter registers; a reset mid-game aborts to a fresh level 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INPUT;
            n_r     <= {IDX_W{1'b0}};
            i_r     <= {IDX_W{1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
            lives_r <= LIVES_C;
            won_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            n_r     <= n_nxt_s;
            i_r     <= i_nxt_s;
            hold_r  <= hold_nxt_s;
            lives_r <= lives_nxt_s;
            won_r   <= won_nxt_s;
        end
    end

    // Next-state and counter update; exactly one transition per step strobe.
    always_comb begin
        state_nxt_s = state_r;
        n_nxt_s     = n_r;
        i_nxt_s     = i_r;
        hold_nxt_s  = hold_r;
        lives_nxt_s = lives_r;
        won_nxt_s   = won_r;
        if (bus.step) begin
            case (state_r)
                ST_INPUT: begin
                    if (bus.valid_input) begin
                        n_nxt_s     = n_r + IDX_W'(1);
                        i_nxt_s     = {IDX_W{1'b0}};
                        hold_nxt_s  = {HOLD_W{1'b0}};
                        state_nxt_s = ST_PLAYBACK;
                    end else begin
                        state_nxt_s = ST_INPUT;
                    end
                end
                ST_PLAYBACK: begin
                    if (hold_r != HOLD_LAST) begin
                        hold_nxt_s = hold_r + HOLD_W'(1);
                    end else begin
                        hold_nxt_s = {HOLD_W{1'b0}};
                        if (i_r == last_s) begin
                            i_nxt_s     = {IDX_W{1'b0}};
                            state_nxt_s = ST_REPEAT;
                        end else begin
                            i_nxt_s = i_r + IDX_W'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (bus.valid_repeat) begin
                        if (i_r != last_s) begin
                            i_nxt_s = i_r + IDX_W'(1);
                        end else begin
                            i_nxt_s = {IDX_W{1'b0}};
                            if (n_r == DEPTH_C) begin
                                won_nxt_s   = 1'b1;
                                state_nxt_s = ST_DONE;
                            end else begin
                                state_nxt_s = ST_INPUT;
                            end
                        end
                    end else begin
                        lives_nxt_s = lives_r - LIFE_W'(1);
                        if (lives_r == LIFE_W'(1)) begin
                            won_nxt_s   = 1'b0;
                            state_nxt_s = ST_DONE;
                        end else begin
                            i_nxt_s     = {IDX_W{1'b0}};
                            hold_nxt_s  = {HOLD_W{1'b0}};
                            state_nxt_s = ST_PLAYBACK;
                        end
                    end
                end
                ST_DONE: begin
                    // Replay the final sequence cyclically until reset.
                    if (i_r == last_s) begin
                        i_nxt_s = {IDX_W{1'b0}};
                    end else begin
                        i_nxt_s = i_r + IDX_W'(1);
                    end
                end
                default: begin
                    state_nxt_s = ST_INPUT;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Mode LED / pattern-source decode and memory write strobe from state.
    always_comb begin
        mode_leds_s         = 3'b001;
        input_led_pattern_s = 1'b1;
        mem_we_s            = 1'b0;
        case (state_r)
            ST_INPUT: begin
                mode_leds_s         = 3'b001;
                input_led_pattern_s = 1'b1;
                mem_we_s            = bus.step & bus.valid_input;
            end
            ST_PLAYBACK: begin
                mode_leds_s         = 3'b010;
                input_led_pattern_s = 1'b0;
            end
            ST_REPEAT: begin
                mode_leds_s         = 3'b100;
                input_led_pattern_s = 1'b1;
            end
            ST_DONE: begin
                mode_leds_s         = 3'b111;
                input_led_pattern_s = 1'b0;
            end
            default: begin
                mode_leds_s         = 3'b001;
                input_led_pattern_s = 1'b1;
            end
        endcase
    end

    assign bus.mem_we            = mem_we_s;
    assign bus.mode_leds         = mode_leds_s;
    assign bus.input_led_pattern = input_led_pattern_s;
    assign bus.n                 = n_r;
    assign bus.i                 = i_r;
    assign bus.lives             = lives_r;
    assign bus.won               = won_r;

endmodule

// File: tb/tb_simon_control_gen.sv
// Table-driven bench for simon_control_gen with DEPTH=2, HOLD=2, LIVES=2.
module tb_simon_control_gen;

    localparam int DEPTH  = 2;
    localparam int IDX_W  = 2;
    localparam int HOLD   = 2;
    localparam int LIVES  = 2;
    localparam int LIFE_W = 2;

    typedef struct {
        logic       step;
        logic       vi;
        logic       vr;
        logic       mw;     // mem_we expected before the edge
        logic [2:0] mode;   // outputs expected after the edge
        logic [1:0] n;
        logic [1:0] i;
        logic [1:0] lives;
        logic       won;
        logic       ilp;
    } vec_t;

    logic clk;
    logic rst;
    int   total_cnt;
    int   pass_cnt;
    vec_t tbl[$];
    vec_t exp_q[$];
    int   a_lo, a_hi, b_lo, b_hi, c_lo, c_hi;

    simon_control_gen_if #(.IDX_W(IDX_W), .LIFE_W(LIFE_W)) bus ();

    simon_control_gen #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .HOLD(HOLD), .LIVES(LIVES), .LIFE_W(LIFE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s (vec %0d): got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic vi, input logic vr, input logic mw,
                       input logic [2:0] mode, input logic [1:0] n, input logic [1:0] i,
                       input logic [1:0] lives, input logic won, input logic ilp);
        vec_t v;
        v.step = s; v.vi = vi; v.vr = vr; v.mw = mw; v.mode = mode;
        v.n = n; v.i = i; v.lives = lives; v.won = won; v.ilp = ilp;
        tbl.push_back(v);
    endtask

    task automatic chk_reset_vals(input int tag);
        chk("rst_mode", tag, 32'(bus.mode_leds), 32'(3'b001));
        chk("rst_n", tag, 32'(bus.n), 32'd0);
        chk("rst_i", tag, 32'(bus.i), 32'd0);
        chk("rst_lives", tag, 32'(bus.lives), 32'(LIVES));
        chk("rst_won", tag, 32'(bus.won), 32'd0);
        chk("rst_ilp", tag, 32'(bus.input_led_pattern), 32'd1);
        chk("rst_mem_we", tag, 32'(bus.mem_we), 32'd0);
    endtask

    task automatic run(input int lo, input int hi);
        vec_t e;
        for (int k = lo; k < hi; k++) begin
            @(negedge clk);
            bus.step = tbl[k].step;
            bus.valid_input = tbl[k].vi;
            bus.valid_repeat = tbl[k].vr;
            exp_q.push_back(tbl[k]);
            #1;
            chk("mem_we", k, 32'(bus.mem_we), 32'(tbl[k].mw));
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", k, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("mode_leds", k, 32'(bus.mode_leds), 32'(e.mode));
                chk("n", k, 32'(bus.n), 32'(e.n));
                chk("i", k, 32'(bus.i), 32'(e.i));
                chk("lives", k, 32'(bus.lives), 32'(e.lives));
                chk("won", k, 32'(bus.won), 32'(e.won));
                chk("ilp", k, 32'(bus.input_led_pattern), 32'(e.ilp));
            end
        end
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic sync_reset(input int tag);
        @(negedge clk);
        rst = 1'b1;
        bus.step = 1'b0;
        bus.valid_input = 1'b0;
        bus.valid_repeat = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt = 0;
        rst = 1'b1;
        bus.step = 1'b0;
        bus.valid_input = 1'b0;
        bus.valid_repeat = 1'b0;

        // Segment A: level 1, level 2, two losses, DONE replay.
        a_lo = tbl.size();
        add(1, 0, 0, 0, 3'b001, 0, 0, 2, 0, 1);
        add(1, 1, 0, 1, 3'b010, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b100, 1, 0, 2, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 3'b100, 1, 0, 2, 0, 1);
        add(1, 0, 1, 0, 3'b001, 1, 0, 2, 0, 1);
        for (int k = 0; k < 5; k++) add(0, 1, 1, 0, 3'b001, 1, 0, 2, 0, 1);
        add(1, 1, 0, 1, 3'b010, 2, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 1, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 1, 2, 0, 0);
        add(1, 0, 0, 0, 3'b100, 2, 0, 2, 0, 1);
        add(1, 0, 0, 0, 3'b010, 2, 0, 1, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 0, 1, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 1, 1, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 1, 1, 0, 0);
        add(1, 0, 0, 0, 3'b100, 2, 0, 1, 0, 1);
        add(1, 0, 0, 0, 3'b111, 2, 0, 0, 0, 0);
        add(1, 0, 0, 0, 3'b111, 2, 1, 0, 0, 0);
        add(1, 0, 0, 0, 3'b111, 2, 0, 0, 0, 0);
        add(1, 1, 1, 0, 3'b111, 2, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 3'b111, 2, 1, 0, 0, 0);
        a_hi = tbl.size();

        // Segment B: fresh game won at n=DEPTH.
        b_lo = tbl.size();
        add(1, 1, 0, 1, 3'b010, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b100, 1, 0, 2, 0, 1);
        add(1, 0, 1, 0, 3'b001, 1, 0, 2, 0, 1);
        add(1, 1, 0, 1, 3'b010, 2, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 1, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 1, 2, 0, 0);
        add(1, 0, 0, 0, 3'b100, 2, 0, 2, 0, 1);
        add(1, 0, 1, 0, 3'b100, 2, 1, 2, 0, 1);
        add(1, 0, 1, 0, 3'b111, 2, 0, 2, 1, 0);
        add(1, 0, 0, 0, 3'b111, 2, 1, 2, 1, 0);
        b_hi = tbl.size();

        // Segment C: reach mid-playback at n=2 for the async reset.
        c_lo = tbl.size();
        add(1, 1, 0, 1, 3'b010, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 1, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b100, 1, 0, 2, 0, 1);
        add(1, 0, 1, 0, 3'b001, 1, 0, 2, 0, 1);
        add(1, 1, 0, 1, 3'b010, 2, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 0, 2, 0, 0);
        add(1, 0, 0, 0, 3'b010, 2, 1, 2, 0, 0);
        c_hi = tbl.size();

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals(-1);

        run(a_lo, a_hi);
        sync_reset(-2);
        run(b_lo, b_hi);
        sync_reset(-3);
        run(c_lo, c_hi);

        // Asynchronous reset between edges while in PLAYBACK with n=2.
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals(-4);
        @(negedge clk);
        rst = 1'b0;
        bus.step = 1'b1;
        bus.valid_input = 1'b1;
        #1;
        chk("post_rst_mem_we", -5, 32'(bus.mem_we), 32'd1);
        chk("post_rst_addr", -5, 32'(bus.n), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_n", -5, 32'(bus.n), 32'd1);
        chk("post_rst_mode", -5, 32'(bus.mode_leds), 32'(3'b010));
        @(negedge clk);
        bus.step = 1'b0;
        bus.valid_input = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/simon_control_gen.md
Name: simon_control_gen

Overview:
- Parametrised next-generation Simon game controller.
- Owns the level counter n, the playback/repeat index i, a playback hold timer and a lives counter internally.
- Replaces the external seq_remain/clear_i/increment_* handshake with its own counters.
- Sits between the pattern datapath (stored-pattern memory, switch/LED compare) and the mode LEDs. Advances only on a one-cycle step strobe, so the system clock runs free.

Parameters:
DEPTH, 16, maximum sequence length; reaching and repeating DEPTH patterns wins the game
IDX_W, 5, width of n and i; must satisfy 2**IDX_W > DEPTH
HOLD, 1, number of step strobes each stored pattern is shown during playback (>=1)
LIVES, 3, wrong repeats tolerated before losing (>=1)
LIFE_W, 2, width of lives output; must hold LIVES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
step  in  1  advance strobe; all state/counter updates occur only on clk edges with step=1
valid_input  in  1  user switch pattern is legal for entry (datapath compare)
valid_repeat  in  1  user pattern equals stored pattern at address i
mem_we  out  1  write current user pattern to stored-pattern memory at address n
n  out  IDX_W  number of stored patterns (current level)
i  out  IDX_W  playback/repeat/display index into memory
input_led_pattern  out  1  1: pattern LEDs show user switches; 0: show memory[i]
mode_leds  out  3  INPUT=001, PLAYBACK=010, REPEAT=100, DONE=111
lives  out  LIFE_W  remaining lives
won  out  1  valid in DONE: 1 win, 0 loss

Behaviour:
- Async reset: state=INPUT, n=0, i=0, hold=0, lives=LIVES, won=0, mode_leds=001, input_led_pattern=1, mem_we=0. Reset mid-game aborts immediately; memory contents are irrelevant because n=0.
- mode_leds and input_led_pattern decode combinationally from state. input_led_pattern=1 in INPUT and REPEAT, 0 in PLAYBACK and DONE.
- mem_we = (state==INPUT) & step & valid_input. This is combinational and uses the pre-increment n as the address.
- step=0: every register holds, regardless of other inputs.
- INPUT:
  - step & valid_input: n<=n+1, i<=0, hold<=0, go to PLAYBACK.
  - step & !valid_input: stay, nothing changes.
- PLAYBACK:
  - On step with hold<HOLD-1: hold<=hold+1.
  - On step with hold==HOLD-1: hold<=0, then:
    - if i==n-1: i<=0, go to REPEAT;
    - else i<=i+1.
  - Inputs valid_* are ignored.
- REPEAT, step & valid_repeat:
  - if i<n-1: i<=i+1;
  - else i<=0, and if n==DEPTH: won<=1, go to DONE; otherwise go to INPUT.
- REPEAT, step & !valid_repeat:
  - lives<=lives-1;
  - if lives==1: won<=0, go to DONE;
  - else i<=0, hold<=0, go to PLAYBACK (replay same level, n unchanged).
- DONE: absorbing until rst. Each step advances i cyclically 0..n-1 (i==n-1 wraps to 0) to replay the final sequence. n, lives, won hold.
- Invariants:
  - n never exceeds DEPTH; INPUT is never entered with n==DEPTH.
  - n>=1 in PLAYBACK, REPEAT and DONE.
  - i<n outside INPUT.
  - lives never underflows.
- Only one transition per step; valid_input and valid_repeat are consulted only in their own state.

Test Plan (bench params DEPTH=2, HOLD=2, LIVES=2):
1. Reset, then step with valid_input=0 -> mode_leds=001, n=0, mem_we=0, input_led_pattern=1. Set valid_input=1 before the edge -> mem_we=1 while step is high; after the edge n=1, i=0, mode_leds=010, input_led_pattern=0.
2. In PLAYBACK with n=1: first step -> still 010, hold advanced. Second step -> mode_leds=100, i=0, input_led_pattern=1. Step=0 for 5 clocks in any state -> no output change.
3. In REPEAT with n=1: step with valid_repeat=1 -> mode_leds=001, n=1, i=0. Next valid input -> n=2, then 4 steps of playback show i=0,0,1,1 before REPEAT.
4. In REPEAT with n=2: step with valid_repeat=0 -> lives=1, mode_leds=010, i=0. After replay, another wrong repeat -> lives=0, mode_leds=111, won=0. Further steps -> i cycles 0,1,0; state stays DONE.
5. Fresh game to n=2, two correct repeats -> mode_leds=111, won=1, n=2, lives=2.
6. Assert rst asynchronously (between edges) while in PLAYBACK with n=2 -> outputs immediately return to the reset values above; next valid input writes address 0.
